pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers, and inserts a bubble into MEM/WB.
- Resolves three events: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits (with a timeout error).
- Sits beside the pipeline registers; consumes ID/EX decode fields and the data-memory handshake.

Parameters:
MEM_TIMEOUT, 16, max consecutive busy cycles of a data-memory access before entering ERR (must be >=2)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-low (rst=0 resets on posedge clk)
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_rd  in  5  destination register of instruction in EX
ex_regw  in  1  EX instruction writes the register file
ex_mem2r  in  1  EX instruction is a load
branch_taken  in  1  branch/jump in EX is taken this cycle
dm_req  in  1  MEM stage is accessing data memory
dm_ready  in  1  data memory completes the access this cycle
pc_we  out  1  PC write enable
if_id_we  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_we  out  1  ID/EX write enable
id_ex_flush  out  1  ID/EX loads NOP (bubble)
ex_mem_we  out  1  EX/MEM write enable
mem_wb_bubble  out  1  MEM/WB loads zeros (RegW=0, Mem2R=0)
err  out  1  sticky memory-timeout error
stall_cycles  out  CNT_W  count of cycles with pc_we=0
state  out  2  FSM state: RUN=0, MEMWAIT=1, ERR=2

Behaviour:
- Registered: state, wait_cnt (width clog2(MEM_TIMEOUT)+1), err, stall_cycles. All other outputs combinational from state and inputs.
- Reset (rst=0 at posedge): state=RUN, wait_cnt=0, err=0, stall_cycles=0.
- While rst=0: all *_we=0, all flushes=0, mem_wb_bubble=0.
- Definitions:
  - busy = dm_req & ~dm_ready.
  - load_use = ex_mem2r & ex_regw & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- Default (RUN, no event): all *_we=1, flushes=0, bubble=0.
- RUN priority: busy > branch_taken > load_use.
  - busy: pc_we, if_id_we, id_ex_we, ex_mem_we =0; mem_wb_bubble=1; wait_cnt<=1; next MEMWAIT.
  - branch_taken: all we=1; if_id_flush=1; id_ex_flush=1; load_use ignored because the ID instruction is squashed.
  - load_use: pc_we=0; if_id_we=0; id_ex_flush=1; ex_mem_we=1. Exactly one bubble, no state change; the next cycle's load_use is false by construction.
- MEMWAIT:
  - busy: same freeze outputs as above.
    - wait_cnt<wait_cnt+1.
    - If wait_cnt==MEM_TIMEOUT-1: next ERR, err<=1.
  - dm_ready=1: release cycle. Outputs follow RUN rules for branch_taken/load_use, with busy treated as 0. wait_cnt<=0; next RUN.
  - dm_ready in the same cycle as the timeout threshold: ready wins, no error.
  - dm_req dropped without dm_ready: treated as release, identical to ready.
- ERR: all *_we=0, flushes=0, mem_wb_bubble=1. err=1. Stays until rst=0.
- stall_cycles: +1 on each non-reset posedge where pc_we=0, ERR included. Saturates at 2^CNT_W-1.
- Reset mid-MEMWAIT or in ERR: returns to RUN on that edge; pending access is abandoned.

Test Plan:
- Idle RUN, no events -> all *_we=1, flushes=0, stall_cycles stays 0 for 10 cycles.
- ex_mem2r=1, ex_regw=1, ex_rd=5, id_rs=5 for one cycle -> pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Load-use and branch_taken asserted together -> if_id_flush=1, id_ex_flush=1, pc_we=1, no stall.
- dm_req=1, dm_ready low 3 cycles, then high -> 3 cycles of freeze with mem_wb_bubble=1 and state=1; 4th cycle all we=1; state=0; stall_cycles=3.
- MEM_TIMEOUT=4, dm_req=1, dm_ready=0 held -> after 4 busy cycles state=2, err=1, all we=0. Hold 5 more cycles -> unchanged. rst=0 one edge -> state=0, err=0, stall_cycles=0.
- dm_ready=1 exactly on the 4th busy cycle (MEM_TIMEOUT=4) -> release to RUN, err stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for pipe_hazard_ctrl: ID/EX decode fields and data-memory
// handshake in, register write-enables/flushes and status out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rd;
    logic             ex_regw;
    logic             ex_mem2r;
    logic             branch_taken;
    logic             dm_req;
    logic             dm_ready;

    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_we;
    logic             id_ex_flush;
    logic             ex_mem_we;
    logic             mem_wb_bubble;
    logic             err;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       state;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rd, ex_regw, ex_mem2r,
               branch_taken, dm_req, dm_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, mem_wb_bubble, err, stall_cycles, state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rd, ex_regw, ex_mem2r,
               branch_taken, dm_req, dm_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, mem_wb_bubble, err, stall_cycles, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// squashes and data-memory wait freezes with a sticky timeout error.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t           st_q, st_nxt;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_nxt;
    logic             err_q, err_nxt;
    logic [CNT_W-1:0] stall_q;

    logic busy;
    logic load_use;
    logic apply_hazards;

    logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble;

    assign busy     = bus.dm_req & ~bus.dm_ready;
    assign load_use = bus.ex_mem2r & bus.ex_regw & (bus.ex_rd != 5'd0) &
                      ((bus.ex_rd == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rd == bus.id_rt)));

    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_we      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_we     = 1'b1;
        mem_wb_bubble = 1'b0;
        st_nxt        = st_q;
        wait_cnt_nxt  = wait_cnt_q;
        err_nxt       = err_q;
        apply_hazards = 1'b0;

        unique case (st_q)
            RUN: begin
                if (busy) begin
                    pc_we         = 1'b0;
                    if_id_we      = 1'b0;
                    id_ex_we      = 1'b0;
                    ex_mem_we     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    wait_cnt_nxt  = WC_W'(1);
                    st_nxt        = MEMWAIT;
                end else begin
                    apply_hazards = 1'b1;
                end
            end
            MEMWAIT: begin
                if (busy) begin
                    pc_we         = 1'b0;
                    if_id_we      = 1'b0;
                    id_ex_we      = 1'b0;
                    ex_mem_we     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
                        st_nxt  = ERR;
                        err_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt_q + WC_W'(1);
                    end
                end else begin
                    // ready or a dropped request both release; this cycle obeys RUN hazard rules
                    apply_hazards = 1'b1;
                    wait_cnt_nxt  = '0;
                    st_nxt        = RUN;
                end
            end
            ERR: begin
                pc_we         = 1'b0;
                if_id_we      = 1'b0;
                id_ex_we      = 1'b0;
                ex_mem_we     = 1'b0;
                mem_wb_bubble = 1'b1;
            end
            default: begin
                st_nxt = RUN;
            end
        endcase

        if (apply_hazards) begin
            if (bus.branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        if (!rst) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_we      = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q       <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            stall_q    <= '0;
        end else begin
            st_q       <= st_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            err_q      <= err_nxt;
            if (!pc_we && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_we         = pc_we;
    assign bus.if_id_we      = if_id_we;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_we      = id_ex_we;
    assign bus.id_ex_flush   = id_ex_flush;
    assign bus.ex_mem_we     = ex_mem_we;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.err           = err_q;
    assign bus.stall_cycles  = stall_q;
    assign bus.state         = st_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and a 4-bit stall counter
// so that both the timeout and counter saturation are reachable in a short run.
module tb_pipe_hazard_ctrl;
    localparam int CW = 4;

    // control vector order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble
    localparam logic [6:0] C_RST  = 7'b000_0000;
    localparam logic [6:0] C_IDLE = 7'b110_1010;
    localparam logic [6:0] C_LU   = 7'b000_1110;
    localparam logic [6:0] C_BR   = 7'b111_1110;
    localparam logic [6:0] C_FRZ  = 7'b000_0001;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   exp_stall;
    logic [6:0] ctl;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign ctl = {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_we,
                  bus.id_ex_flush, bus.ex_mem_we, bus.mem_wb_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_rd        = 5'd0;
        bus.ex_regw      = 1'b0;
        bus.ex_mem2r     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.dm_req       = 1'b0;
        bus.dm_ready     = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        bus.ex_mem2r = 1'b1;
        bus.ex_regw  = 1'b1;
        bus.ex_rd    = rd;
        bus.id_rs    = rd;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        exp_stall = 0;
        rst = 1'b0;
        clear_in();
        tick();
        tick();
        #3;
        chk("reset_ctl", 32'(ctl), 32'(C_RST));
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_stall", 32'(bus.stall_cycles), 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            #3;
            chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
            tick();
        end
        chk("idle_stall", 32'(bus.stall_cycles), 32'd0);
        chk("idle_state", 32'(bus.state), 32'd0);

        set_lu(5'd5);
        #3;
        chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
        tick();
        exp_stall++;
        clear_in();
        chk("lu_rs_stall", 32'(bus.stall_cycles), 32'(exp_stall));
        #3;
        chk("after_lu_ctl", 32'(ctl), 32'(C_IDLE));
        tick();

        bus.ex_mem2r = 1'b1; bus.ex_regw = 1'b1; bus.ex_rd = 5'd9;
        bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1; bus.id_rs = 5'd3;
        #3;
        chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
        tick();
        exp_stall++;
        bus.id_uses_rt = 1'b0;
        #3;
        chk("rt_unused_ctl", 32'(ctl), 32'(C_IDLE));
        tick();

        clear_in();
        set_lu(5'd0);
        #3;
        chk("lu_r0_ctl", 32'(ctl), 32'(C_IDLE));
        tick();

        clear_in();
        bus.ex_regw = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
        #3;
        chk("not_load_ctl", 32'(ctl), 32'(C_IDLE));
        tick();

        clear_in();
        set_lu(5'd7);
        bus.branch_taken = 1'b1;
        #3;
        chk("lu_branch_ctl", 32'(ctl), 32'(C_BR));
        tick();
        chk("lu_branch_stall", 32'(bus.stall_cycles), 32'(exp_stall));
        clear_in();

        // memory wait of three busy cycles then ready, counted from a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_stall = 0;
        bus.dm_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("wait_ctl", 32'(ctl), 32'(C_FRZ));
            chk("wait_state", 32'(bus.state), (i == 0) ? 32'd0 : 32'd1);
            tick();
            exp_stall++;
        end
        bus.dm_ready = 1'b1;
        #3;
        chk("release_ctl", 32'(ctl), 32'(C_IDLE));
        chk("release_state_pre", 32'(bus.state), 32'd1);
        tick();
        clear_in();
        chk("release_state", 32'(bus.state), 32'd0);
        chk("release_stall", 32'(bus.stall_cycles), 32'(exp_stall));

        bus.dm_req = 1'b1;
        tick();
        exp_stall++;
        bus.dm_ready = 1'b1;
        set_lu(5'd12);
        #3;
        chk("release_lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        exp_stall++;
        clear_in();
        chk("release_lu_state", 32'(bus.state), 32'd0);
        chk("release_lu_stall", 32'(bus.stall_cycles), 32'(exp_stall));

        bus.dm_req = 1'b1;
        tick();
        tick();
        exp_stall += 2;
        chk("drop_state_pre", 32'(bus.state), 32'd1);
        bus.dm_req = 1'b0;
        #3;
        chk("drop_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("drop_state", 32'(bus.state), 32'd0);

        bus.dm_req = 1'b1;
        tick();
        tick();
        tick();
        exp_stall += 3;
        bus.dm_ready = 1'b1;
        #3;
        chk("thresh_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        clear_in();
        chk("thresh_state", 32'(bus.state), 32'd0);
        chk("thresh_err", 32'(bus.err), 32'd0);
        chk("thresh_stall", 32'(bus.stall_cycles), 32'(exp_stall));

        bus.dm_req = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.dm_req = 1'b0;
        #3;
        chk("mid_rst_ctl", 32'(ctl), 32'(C_RST));
        tick();
        rst = 1'b1;
        exp_stall = 0;
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall_cycles), 32'd0);

        bus.dm_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("to_ctl", 32'(ctl), 32'(C_FRZ));
            tick();
            exp_stall++;
            if (i < 3) begin
                chk("to_err_early", 32'(bus.err), 32'd0);
            end
        end
        chk("to_state", 32'(bus.state), 32'd2);
        chk("to_err", 32'(bus.err), 32'd1);
        chk("to_stall", 32'(bus.stall_cycles), 32'(exp_stall));
        bus.dm_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("err_ctl", 32'(ctl), 32'(C_FRZ));
            tick();
            exp_stall++;
            chk("err_state", 32'(bus.state), 32'd2);
            chk("err_sticky", 32'(bus.err), 32'd1);
        end
        chk("err_stall", 32'(bus.stall_cycles), 32'(exp_stall));
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("stall_sat", 32'(bus.stall_cycles), 32'd15);

        rst = 1'b0;
        #3;
        chk("err_rst_ctl", 32'(ctl), 32'(C_RST));
        tick();
        rst = 1'b1;
        chk("err_rst_state", 32'(bus.state), 32'd0);
        chk("err_rst_err", 32'(bus.err), 32'd0);
        chk("err_rst_stall", 32'(bus.stall_cycles), 32'd0);
        #3;
        chk("err_rst_idle", 32'(ctl), 32'(C_IDLE));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
